fifo_rr_arb: RTL and testbench

FIFO_RR_ARB -- requirements
Module: fifo_rr_arb

---
 rtl/fifo_rr_arb_if.sv | 13 +
 rtl/fifo_rr_arb.sv | 110 +++++++++++
 tb/tb_fifo_rr_arb.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rr_arb_if.sv
// Valid/ready data transfer interface.
//   valid : producer has a beat on data
//   ready : consumer accepts the beat; a transfer happens when both are high
//   data  : W-bit payload
// producer modport drives valid/data, consumer modport drives ready.
interface dti #(parameter int W = 16);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport producer (output valid, output data, input ready);
  modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/fifo_rr_arb.sv
// Round-robin arbiter for NUM valid/ready requesters feeding one output.
// It adds no storage and no latency: the selected requester is steered
// straight to dout, tagged with its index.
// A grant is held through a packet (EOT_LOCK=1, end marked by data bit
// DIN-1) or for at most BURST transfers. The search pointer advances past
// the released requester.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   din  : NUM requester channels (consumer side)
//   dout : arbitrated output, data = {index[IW-1:0], payload[DIN-1:0]}
module fifo_rr_arb #(
  parameter int NUM      = 4,
  parameter int DIN      = 16,
  parameter int BURST    = 8,
  parameter int EOT_LOCK = 1
) (
  input  logic clk,
  input  logic rst,
  dti.consumer din [NUM],
  dti.producer dout
);
  localparam int IW = ($clog2(NUM) > 1) ? $clog2(NUM) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t  state, state_n;
  logic [IW-1:0] ptr, ptr_n, gnt, gnt_n;
  logic [7:0]    bcnt, bcnt_n;

  logic [NUM-1:0]          req_v;
  logic [NUM-1:0]          req_r;
  logic [NUM-1:0][DIN-1:0] req_d;

  logic [IW-1:0] rr_sel, cand, sel;
  logic          rr_hit, active, out_v, hs, eot, last;

  for (genvar g = 0; g < NUM; g++) begin : g_lane
    assign req_v[g]     = din[g].valid;
    assign req_d[g]     = din[g].data;
    assign din[g].ready = req_r[g];
  end

  // First valid requester starting at ptr, wrapping modulo NUM.
  always_comb begin
    rr_hit = 1'b0;
    rr_sel = '0;
    cand   = '0;
    for (int k = 0; k < NUM; k++) begin
      if (int'(ptr) + k >= NUM) cand = IW'(int'(ptr) + k - NUM);
      else                      cand = IW'(int'(ptr) + k);
      if (!rr_hit && req_v[cand]) begin
        rr_hit = 1'b1;
        rr_sel = cand;
      end
    end
  end

  assign sel    = (state == LOCK) ? gnt : rr_sel;
  // In IDLE with nobody valid there is no owner, so no ready is given out.
  assign active = !rst && ((state == LOCK) || rr_hit);
  assign out_v  = active && req_v[sel];
  assign hs     = out_v && dout.ready;
  assign eot    = (EOT_LOCK != 0) && req_d[sel][DIN-1];
  assign last   = eot || (({1'b0, bcnt} + 9'd1) == 9'(BURST));

  assign dout.valid = out_v;
  assign dout.data  = {sel, req_d[sel]};

  always_comb begin
    req_r = '0;
    if (active) req_r[sel] = dout.ready;
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    ptr_n   = ptr;
    bcnt_n  = bcnt;
    if (hs) begin
      if (last) begin
        state_n = IDLE;
        bcnt_n  = '0;
        ptr_n   = (sel == IW'(NUM - 1)) ? '0 : sel + IW'(1);
      end else begin
        state_n = LOCK;
        gnt_n   = sel;
        bcnt_n  = bcnt + 8'd1;
      end
    end else if (out_v) begin
      // Offered but stalled: freeze the selection until it is taken.
      state_n = LOCK;
      gnt_n   = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
      bcnt  <= bcnt_n;
    end
  end
endmodule

// File: tb/tb_fifo_rr_arb.sv
module tb_fifo_rr_arb;
  localparam int DW = 16;
  localparam int OW = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cfg = 0;
  logic [3:0]         sv   = '0;
  logic [3:0][DW-1:0] sd   = '0;
  logic               srdy = 1'b0;

  dti #(.W(DW)) i0 [4] ();
  dti #(.W(DW)) i1 [4] ();
  dti #(.W(DW)) i2 [3] ();
  dti #(.W(OW)) o0 ();
  dti #(.W(OW)) o1 ();
  dti #(.W(OW)) o2 ();

  fifo_rr_arb #(.NUM(4), .DIN(DW), .BURST(8), .EOT_LOCK(1)) u0 (.clk(clk), .rst(rst), .din(i0), .dout(o0));
  fifo_rr_arb #(.NUM(4), .DIN(DW), .BURST(2), .EOT_LOCK(0)) u1 (.clk(clk), .rst(rst), .din(i1), .dout(o1));
  fifo_rr_arb #(.NUM(3), .DIN(DW), .BURST(8), .EOT_LOCK(1)) u2 (.clk(clk), .rst(rst), .din(i2), .dout(o2));

  logic [3:0] r0, r1, r2;
  for (genvar g = 0; g < 4; g++) begin : g_drv4
    assign i0[g].valid = (cfg == 0) && sv[g];
    assign i0[g].data  = sd[g];
    assign r0[g]       = i0[g].ready;
    assign i1[g].valid = (cfg == 1) && sv[g];
    assign i1[g].data  = sd[g];
    assign r1[g]       = i1[g].ready;
  end
  for (genvar g = 0; g < 3; g++) begin : g_drv3
    assign i2[g].valid = (cfg == 2) && sv[g];
    assign i2[g].data  = sd[g];
    assign r2[g]       = i2[g].ready;
  end
  assign r2[3] = 1'b0;
  assign o0.ready = srdy;
  assign o1.ready = srdy;
  assign o2.ready = srdy;

  logic          ov;
  logic [OW-1:0] od;
  logic [3:0]    orv;
  always_comb begin
    ov = o0.valid; od = o0.data; orv = r0;
    if (cfg == 1)      begin ov = o1.valid; od = o1.data; orv = r1; end
    else if (cfg == 2) begin ov = o2.valid; od = o2.data; orv = r2; end
  end

  // Reference model: rotating priority list, packet/burst grant holding.
  int m_num, m_burst, m_eot, m_ptr, m_gnt, m_cnt;
  bit m_lock;

  task automatic model_reset();
    m_lock = 0; m_ptr = 0; m_gnt = 0; m_cnt = 0;
  endtask

  function automatic void model_eval(output bit ev, output int es);
    ev = 0; es = -1;
    if (m_lock) begin
      es = m_gnt; ev = sv[m_gnt];
    end else begin
      for (int k = 0; k < m_num; k++) begin
        int i;
        i = (m_ptr + k) % m_num;
        if (es < 0 && sv[i]) begin es = i; ev = 1; end
      end
    end
  endfunction

  task automatic model_commit(input bit ev, input int es);
    if (ev && srdy) begin
      if ((m_eot != 0 && sd[es][15]) || m_cnt + 1 == m_burst) begin
        m_lock = 0; m_cnt = 0; m_ptr = (es + 1) % m_num;
      end else begin
        m_lock = 1; m_gnt = es; m_cnt++;
      end
    end else if (ev) begin
      m_lock = 1; m_gnt = es;
    end
  endtask

  task automatic do_reset(input int c);
    cfg = c; sv = '0; srdy = 0; rst = 1;
    case (c)
      0: begin m_num = 4; m_burst = 8; m_eot = 1; end
      1: begin m_num = 4; m_burst = 2; m_eot = 0; end
      default: begin m_num = 3; m_burst = 8; m_eot = 1; end
    endcase
    model_reset();
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    cfg = 0; sv = 4'hf; srdy = 1; rst = 1;
    for (int i = 0; i < 4; i++) sd[i] = 16'h8000 | 16'(i);
    @(negedge clk);
    total++;
    if (ov !== 1'b0 || orv !== 4'b0) begin
      bad++;
      $display("FAIL reset_outputs: got valid=%b ready=%b want valid=0 ready=0000", ov, orv);
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    total++;
    if (ov !== 1'b1 || od[17:16] !== 2'd0) begin
      bad++;
      $display("FAIL reset_first_grant: got valid=%b idx=%0d want valid=1 idx=0", ov, od[17:16]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rr_order();
    int exp [5] = '{0, 1, 2, 3, 0};
    do_reset(0);
    sv = 4'hf; srdy = 1;
    for (int i = 0; i < 4; i++) sd[i] = 16'h8000 | 16'(i);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      total++;
      if (ov !== 1'b1 || od[17:16] !== exp[n][1:0] || od[15:0] !== sd[exp[n]]) begin
        bad++;
        $display("FAIL rr_order beat %0d: got v=%b idx=%0d data=%h want idx=%0d data=%h",
                 n, ov, od[17:16], od[15:0], exp[n], sd[exp[n]]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_packet();
    int exp [4] = '{1, 1, 1, 2};
    do_reset(0);
    srdy = 1; sd[2] = 16'h8200;
    for (int n = 0; n < 4; n++) begin
      sv = {1'b0, 1'b1, (n < 3), 1'b0};
      sd[1] = (n == 2) ? 16'h8103 : (16'h0100 | 16'(n + 1));
      @(negedge clk);
      total++;
      if (ov !== 1'b1 || od[17:16] !== exp[n][1:0] || od[15:0] !== sd[exp[n]]) begin
        bad++;
        $display("FAIL packet beat %0d: got idx=%0d data=%h want idx=%0d data=%h",
                 n, od[17:16], od[15:0], exp[n], sd[exp[n]]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_burst();
    int exp [6] = '{0, 0, 3, 3, 0, 0};
    do_reset(1);
    sv = 4'b1001; srdy = 1;
    for (int i = 0; i < 4; i++) sd[i] = 16'h8000 | 16'(i << 4);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      total++;
      if (ov !== 1'b1 || od[17:16] !== exp[n][1:0]) begin
        bad++;
        $display("FAIL burst beat %0d: got v=%b idx=%0d want idx=%0d", n, ov, od[17:16], exp[n]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold();
    do_reset(0);
    sd[2] = 16'h8222; sd[0] = 16'h8000; sv = 4'b0100; srdy = 0;
    for (int n = 0; n < 7; n++) begin
      int want;
      if (n >= 2) sv[0] = 1'b1;
      if (n == 5) srdy = 1;
      if (n == 6) sv[2] = 1'b0;
      want = (n < 6) ? 2 : 0;
      @(negedge clk);
      total++;
      if (ov !== 1'b1 || od[17:16] !== 2'(want) || od[15:0] !== sd[want] ||
          orv !== (srdy ? (4'b1 << want) : 4'b0)) begin
        bad++;
        $display("FAIL hold cycle %0d: got v=%b idx=%0d data=%h rdy=%b want idx=%0d data=%h",
                 n, ov, od[17:16], od[15:0], orv, want, sd[want]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    do_reset(0);
    sv = 4'b1000; sd[3] = 16'h0301; srdy = 1;
    @(negedge clk);
    total++;
    if (ov !== 1'b1 || od[17:16] !== 2'd3) begin
      bad++;
      $display("FAIL rst_mid beat1: got v=%b idx=%0d want idx=3", ov, od[17:16]);
    end
    @(posedge clk); #1;
    sv = 4'b1010; sd[3] = 16'h0302; sd[1] = 16'h8111; rst = 1;
    @(negedge clk);
    total++;
    if (ov !== 1'b0 || orv !== 4'b0) begin
      bad++;
      $display("FAIL rst_mid during_reset: got v=%b rdy=%b want v=0 rdy=0000", ov, orv);
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    total++;
    if (ov !== 1'b1 || od[17:16] !== 2'd1 || od[15:0] !== 16'h8111) begin
      bad++;
      $display("FAIL rst_mid after: got v=%b idx=%0d data=%h want idx=1 data=8111",
               ov, od[17:16], od[15:0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    int exp [3] = '{2, 0, 1};
    do_reset(2);
    srdy = 1; sd[0] = 16'h8000; sd[1] = 16'h8001; sd[2] = 16'h8002;
    for (int n = 0; n < 3; n++) begin
      sv = (n == 0) ? 4'b0100 : 4'b0011;
      @(negedge clk);
      total++;
      if (ov !== 1'b1 || od[17:16] !== exp[n][1:0] || od[15:0] !== sd[exp[n]]) begin
        bad++;
        $display("FAIL wrap step %0d: got v=%b idx=%0d want idx=%0d", n, ov, od[17:16], exp[n]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random(input int c, input int cycles);
    logic [3:0] mask;
    do_reset(c);
    mask = (c == 2) ? 4'b0111 : 4'b1111;
    for (int n = 0; n < cycles; n++) begin
      bit ev;
      int es;
      logic [OW-1:0] ed;
      logic [3:0] er;
      for (int i = 0; i < 4; i++) begin
        sv[i] = ($urandom_range(0, 9) < 6);
        sd[i] = {($urandom_range(0, 2) == 0), 15'($urandom)};
      end
      sv   = sv & mask;
      srdy = ($urandom_range(0, 9) < 7);
      rst  = ($urandom_range(0, 59) == 0);
      @(negedge clk);
      if (rst) begin
        model_reset();
        total++;
        if (ov !== 1'b0 || orv !== 4'b0) begin
          bad++;
          $display("FAIL random cfg%0d cyc%0d reset: got v=%b rdy=%b want 0", c, n, ov, orv);
        end
      end else begin
        model_eval(ev, es);
        er = '0;
        ed = '0;
        if (es >= 0) begin
          er[es] = srdy;
          ed = {2'(es), sd[es]};
        end
        total++;
        if (ov !== ev || orv !== er || (ev && od !== ed)) begin
          bad++;
          $display("FAIL random cfg%0d cyc%0d: got v=%b data=%h rdy=%b want v=%b data=%h rdy=%b",
                   c, n, ov, od, orv, ev, ed, er);
        end
        model_commit(ev, es);
      end
      @(posedge clk); #1;
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_rr_order();
    test_packet();
    test_burst();
    test_hold();
    test_reset_mid();
    test_wrap();
    test_random(0, 400);
    test_random(1, 300);
    test_random(2, 300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
